ring_stage_scheduler: RTL and testbench



---
 rtl/ring_stage_scheduler.sv | 131 +++++++++++++
 tb/tb_ring_stage_scheduler.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_stage_scheduler.sv
// rtl/ring_stage_scheduler.sv - one-hot start sequencer for a feedback ring of stages
module ring_stage_scheduler #(
    parameter int NUM_STAGES = 3,
    parameter int ITER_W     = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic [ITER_W-1:0]             iter_count,
    input  logic [NUM_STAGES-1:0]         stage_done,
    output logic [NUM_STAGES-1:0]         stage_go,
    output logic [$clog2(NUM_STAGES)-1:0] cur_stage,
    output logic [ITER_W-1:0]             iter_done,
    output logic                          busy,
    output logic                          done,
    output logic                          timeout_err
);

    localparam int SW = $clog2(NUM_STAGES);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);
    localparam logic [TW-1:0] LAST_TICK  = TW'(TIMEOUT - 1);
    localparam logic [NUM_STAGES-1:0] GO_BASE = NUM_STAGES'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        ADVANCE = 3'd3,
        FINISH  = 3'd4,
        ERROR   = 3'd5
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [SW-1:0]     cur_n;
    logic [ITER_W-1:0] iter_n;
    logic [ITER_W-1:0] target;
    logic [ITER_W-1:0] target_n;
    logic [TW-1:0]     timer;
    logic [TW-1:0]     timer_n;
    logic [ITER_W-1:0] iter_inc;

    assign iter_inc = iter_done + ITER_W'(1);

    // Next-state and counter update; abort overrides everything outside IDLE
    always_comb begin
        state_n  = state;
        cur_n    = cur_stage;
        iter_n   = iter_done;
        timer_n  = timer;
        target_n = target;
        case (state)
            IDLE: begin
                if (start) begin
                    target_n = iter_count;
                    iter_n   = '0;
                    cur_n    = '0;
                    state_n  = (iter_count != '0) ? ISSUE : FINISH;
                end
            end
            ISSUE: begin
                timer_n = '0;
                state_n = WAIT;
            end
            WAIT: begin
                if (stage_done[cur_stage]) begin
                    state_n = ADVANCE;
                end else if (timer == LAST_TICK) begin
                    state_n = ERROR;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            ADVANCE: begin
                if (cur_stage != LAST_STAGE) begin
                    cur_n   = cur_stage + SW'(1);
                    state_n = ISSUE;
                end else begin
                    cur_n   = '0;
                    iter_n  = iter_inc;
                    state_n = (iter_inc == target) ? FINISH : ISSUE;
                end
            end
            FINISH: begin
                state_n = IDLE;
            end
            ERROR: begin
                state_n = ERROR;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (abort && (state != IDLE)) begin
            state_n = IDLE;
            cur_n   = cur_stage;
            iter_n  = iter_done;
            timer_n = timer;
        end
    end

    // State, counters and outputs registered together so outputs track the state they belong to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cur_stage   <= '0;
            iter_done   <= '0;
            target      <= '0;
            timer       <= '0;
            stage_go    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            cur_stage   <= cur_n;
            iter_done   <= iter_n;
            target      <= target_n;
            timer       <= timer_n;
            stage_go    <= (state_n == ISSUE) ? (GO_BASE << cur_n) : '0;
            busy        <= (state_n == ISSUE) || (state_n == WAIT) ||
                           (state_n == ADVANCE) || (state_n == FINISH);
            done        <= (state_n == FINISH);
            timeout_err <= (state_n == ERROR);
        end
    end

endmodule

// File: tb/tb_ring_stage_scheduler.sv
// tb/tb_ring_stage_scheduler.sv - directed self-checking bench for ring_stage_scheduler
module tb_ring_stage_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] iter_count = 8'd0;
    logic [2:0] stage_done = 3'd0;
    logic [2:0] stage_go;
    logic [1:0] cur_stage;
    logic [7:0] iter_done;
    logic       busy;
    logic       done;
    logic       timeout_err;

    int n_cmp = 0;
    int n_fail = 0;
    int go_cnt = 0;
    int done_cnt = 0;

    ring_stage_scheduler #(.NUM_STAGES(3), .ITER_W(8), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .iter_count(iter_count), .stage_done(stage_done),
        .stage_go(stage_go), .cur_stage(cur_stage), .iter_done(iter_done),
        .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Pulse counters used to prove exact go/done counts over a window
    always @(posedge clk) begin
        if (!rst) begin
            if (stage_go != 3'd0) go_cnt <= go_cnt + 1;
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From an ISSUE cycle: answer in the first WAIT cycle, land on the state after ADVANCE
    task automatic respond(input logic [2:0] bits);
        step();
        stage_done = bits;
        step();
        stage_done = 3'd0;
        step();
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        n_cmp++; if (stage_go !== 3'd0) begin n_fail++; $display("FAIL reset_go: got %b want 000", stage_go); end
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got busy=%b done=%b err=%b want 0 0 0", busy, done, timeout_err); end
        n_cmp++; if (cur_stage !== 2'd0 || iter_done !== 8'd0) begin n_fail++; $display("FAIL reset_counters: got cur=%0d iter=%0d want 0 0", cur_stage, iter_done); end
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        step();
        n_cmp++; if (busy !== 1'b0 || stage_go !== 3'd0) begin n_fail++; $display("FAIL reset_idle: got busy=%b go=%b want 0 000", busy, stage_go); end
    endtask

    task automatic test_full_run();
        logic [2:0] gos [8];
        logic [2:0] pgo = 3'd0;
        int ng = 0;
        int cnt = 0;
        int ndone = 0;
        int g0;
        int d0;
        logic seen = 1'b0;
        g0 = go_cnt;
        d0 = done_cnt;
        start = 1'b1;
        iter_count = 8'd2;
        step();
        start = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            stage_done = 3'd0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) stage_done = pgo;
            end
            if (stage_go != 3'd0) begin
                if (ng < 8) gos[ng] = stage_go;
                ng++;
                pgo = stage_go;
                cnt = 2;
            end
            if (done) begin
                seen = 1'b1;
                ndone++;
                n_cmp++; if (iter_done !== 8'd2) begin n_fail++; $display("FAIL full_iter_done: got %0d want 2", iter_done); end
                n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy_finish: got %b want 1", busy); end
            end
            step();
        end
        stage_done = 3'd0;
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL full_timeout: got no done want done within 100 cycles"); end
        n_cmp++; if (ng !== 6) begin n_fail++; $display("FAIL full_go_count: got %0d want 6", ng); end
        for (int i = 0; i < 6 && i < ng; i++) begin
            logic [2:0] exp_go;
            exp_go = 3'b001 << (i % 3);
            n_cmp++; if (gos[i] !== exp_go) begin n_fail++; $display("FAIL full_go_order[%0d]: got %b want %b", i, gos[i], exp_go); end
        end
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL full_after: got busy=%b done=%b want 0 0", busy, done); end
        for (int i = 0; i < 5; i++) step();
        n_cmp++; if (go_cnt - g0 !== 6 || done_cnt - d0 !== 1) begin n_fail++; $display("FAIL full_pulse_totals: got go=%0d done=%0d want 6 1", go_cnt - g0, done_cnt - d0); end
    endtask

    task automatic test_zero_iter();
        int g0;
        g0 = go_cnt;
        start = 1'b1;
        iter_count = 8'd0;
        step();
        start = 1'b0;
        n_cmp++; if (done !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL zero_finish: got done=%b busy=%b want 1 1", done, busy); end
        n_cmp++; if (iter_done !== 8'd0) begin n_fail++; $display("FAIL zero_iter_done: got %0d want 0", iter_done); end
        step();
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_after: got done=%b busy=%b want 0 0", done, busy); end
        step();
        n_cmp++; if (go_cnt !== g0) begin n_fail++; $display("FAIL zero_no_go: got %0d pulses want 0", go_cnt - g0); end
    endtask

    task automatic test_timeout();
        start = 1'b1;
        iter_count = 8'd1;
        step();
        start = 1'b0;
        respond(3'b001);
        n_cmp++; if (stage_go !== 3'b010 || cur_stage !== 2'd1) begin n_fail++; $display("FAIL to_issue1: got go=%b cur=%0d want 010 1", stage_go, cur_stage); end
        for (int i = 1; i <= 15; i++) begin
            step();
            n_cmp++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL to_wait[%0d]: got err=%b busy=%b want 0 1", i, timeout_err, busy); end
        end
        step();
        n_cmp++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL to_error: got err=%b busy=%b want 1 0", timeout_err, busy); end
        n_cmp++; if (cur_stage !== 2'd1 || iter_done !== 8'd0) begin n_fail++; $display("FAIL to_hold: got cur=%0d iter=%0d want 1 0", cur_stage, iter_done); end
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        n_cmp++; if (timeout_err !== 1'b1 || stage_go !== 3'd0) begin n_fail++; $display("FAIL to_start_ignored: got err=%b go=%b want 1 000", timeout_err, stage_go); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_cmp++; if (timeout_err !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL to_abort: got err=%b busy=%b want 0 0", timeout_err, busy); end
    endtask

    task automatic test_timeout_edge();
        start = 1'b1;
        iter_count = 8'd1;
        step();
        start = 1'b0;
        for (int i = 0; i < 14; i++) step();
        step();
        stage_done = 3'b001;
        step();
        stage_done = 3'd0;
        n_cmp++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL edge_accept: got err=%b busy=%b want 0 1", timeout_err, busy); end
        step();
        n_cmp++; if (stage_go !== 3'b010) begin n_fail++; $display("FAIL edge_next_go: got %b want 010", stage_go); end
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_spurious();
        start = 1'b1;
        iter_count = 8'd1;
        step();
        start = 1'b0;
        step();
        stage_done = 3'b100;
        step();
        stage_done = 3'd0;
        n_cmp++; if (cur_stage !== 2'd0 || busy !== 1'b1 || stage_go !== 3'd0) begin n_fail++; $display("FAIL spur_ignored: got cur=%0d busy=%b go=%b want 0 1 000", cur_stage, busy, stage_go); end
        step();
        step();
        stage_done = 3'b001;
        step();
        stage_done = 3'd0;
        step();
        n_cmp++; if (cur_stage !== 2'd1 || stage_go !== 3'b010) begin n_fail++; $display("FAIL spur_advance: got cur=%0d go=%b want 1 010", cur_stage, stage_go); end
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_abort_restart();
        int d0;
        start = 1'b1;
        iter_count = 8'd2;
        step();
        start = 1'b0;
        step();
        start = 1'b1;
        iter_count = 8'd0;
        step();
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1 || cur_stage !== 2'd0 || done !== 1'b0) begin n_fail++; $display("FAIL ab_second_start: got busy=%b cur=%0d done=%b want 1 0 0", busy, cur_stage, done); end
        stage_done = 3'b001;
        step();
        stage_done = 3'd0;
        step();
        respond(3'b010);
        respond(3'b100);
        n_cmp++; if (iter_done !== 8'd1 || stage_go !== 3'b001) begin n_fail++; $display("FAIL ab_iter1: got iter=%0d go=%b want 1 001", iter_done, stage_go); end
        respond(3'b001);
        respond(3'b010);
        step();
        n_cmp++; if (cur_stage !== 2'd2 || busy !== 1'b1) begin n_fail++; $display("FAIL ab_wait2: got cur=%0d busy=%b want 2 1", cur_stage, busy); end
        d0 = done_cnt;
        abort = 1'b1;
        stage_done = 3'b100;
        step();
        abort = 1'b0;
        stage_done = 3'd0;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || iter_done !== 8'd1) begin n_fail++; $display("FAIL ab_idle: got busy=%b done=%b iter=%0d want 0 0 1", busy, done, iter_done); end
        for (int i = 0; i < 3; i++) step();
        n_cmp++; if (done_cnt !== d0) begin n_fail++; $display("FAIL ab_no_done: got %0d pulses want 0", done_cnt - d0); end
        start = 1'b1;
        iter_count = 8'd1;
        step();
        start = 1'b0;
        respond(3'b001);
        respond(3'b010);
        respond(3'b100);
        n_cmp++; if (done !== 1'b1 || iter_done !== 8'd1) begin n_fail++; $display("FAIL ab_restart: got done=%b iter=%0d want 1 1", done, iter_done); end
        step();
    endtask

    task automatic test_async_reset();
        start = 1'b1;
        iter_count = 8'd1;
        step();
        start = 1'b0;
        respond(3'b001);
        n_cmp++; if (stage_go !== 3'b010 || cur_stage !== 2'd1) begin n_fail++; $display("FAIL ar_pre: got go=%b cur=%0d want 010 1", stage_go, cur_stage); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (stage_go !== 3'd0 || busy !== 1'b0 || cur_stage !== 2'd0) begin n_fail++; $display("FAIL ar_immediate: got go=%b busy=%b cur=%0d want 000 0 0", stage_go, busy, cur_stage); end
        #3 rst = 1'b0;
        step();
        n_cmp++; if (busy !== 1'b0 || stage_go !== 3'd0 || done !== 1'b0) begin n_fail++; $display("FAIL ar_idle: got busy=%b go=%b done=%b want 0 000 0", busy, stage_go, done); end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_zero_iter();
        test_timeout();
        test_timeout_edge();
        test_spurious();
        test_abort_restart();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
